// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM slave: response codes, read/write FSM
// state encodings and a word-index range helper.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_e;

  // word is ADDR[31:3]; anything at or beyond depth is not backed by storage
  function automatic logic in_range(input logic [28:0] word, input int unsigned depth);
    return 32'(word) < depth;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// DEPTH x 64 storage built from eight byte lanes.
// Ports:
//   ACLK          clock
//   we/waddr      write enable and word address
//   wdata/wstrb   write data and per-byte enables
//   re/raddr      read enable and word address
//   rdata         registered read data, updates only when re was high
// Read and write share one always_ff per lane, so a same-cycle read of the
// word being written returns the old contents.
module sram_bank #(
  parameter  int DEPTH = 1024,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          ACLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [7:0]    wstrb,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  for (genvar i = 0; i < 8; i++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge ACLK) begin
      if (we && wstrb[i]) mem[waddr] <= wdata[8*i +: 8];
      if (re)             rd_q       <= mem[raddr];
    end

    assign rdata[8*i +: 8] = rd_q;
  end

endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI slave in front of a DEPTH x 64 SRAM with programmable
// read and write latency.
// Ports:
//   ACLK, ARESETn                    clock, async active-low reset
//   AR*  (ARVALID/ARREADY/ARADDR/ARPROT)   read address
//   R*   (RVALID/RREADY/RDATA/RLAST/RRESP) read data, always RLAST=1
//   AW*  (AWVALID/AWREADY/AWADDR/AWPROT)   write address
//   W*   (WVALID/WREADY/WDATA/WSTRB/WLAST) write data, WLAST ignored
//   B*   (BVALID/BREADY/BRESP)             write response
// Word index is ADDR[31:3]; words >= DEPTH answer SLVERR and never touch
// storage. Read and write FSMs are independent.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 2
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        ARVALID,
  output logic        ARREADY,
  input  logic [31:0] ARADDR,
  input  logic [2:0]  ARPROT,
  output logic        RVALID,
  input  logic        RREADY,
  output logic [63:0] RDATA,
  output logic        RLAST,
  output logic [1:0]  RRESP,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] AWADDR,
  input  logic [2:0]  AWPROT,
  input  logic        WVALID,
  output logic        WREADY,
  input  logic [63:0] WDATA,
  input  logic [7:0]  WSTRB,
  input  logic        WLAST,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [1:0]  BRESP
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);
  localparam logic [3:0] WR_LAT_C = 4'(WR_LAT);

  // ---------------- read side ----------------
  rd_state_e   r_state, r_next;
  logic [3:0]  r_cnt, r_cnt_nx;
  logic [28:0] r_word, r_word_nx;
  logic [28:0] rd_sel;
  logic        rd_en, r_in;
  logic [63:0] rd_data;

  assign r_in = in_range(r_word, DEPTH);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_word  <= '0;
    end else begin
      r_state <= r_next;
      r_cnt   <= r_cnt_nx;
      r_word  <= r_word_nx;
    end
  end

  // rd_en fires only on the cycle that moves into R_DATA, so the bank's
  // output register doubles as the RDATA hold register while stalled.
  always_comb begin
    r_next    = r_state;
    r_cnt_nx  = r_cnt;
    r_word_nx = r_word;
    rd_en     = 1'b0;
    rd_sel    = r_word;
    case (r_state)
      R_IDLE: if (ARVALID) begin
        r_word_nx = ARADDR[31:3];
        r_cnt_nx  = RD_LAT_C;
        if (RD_LAT_C == 4'd0) begin
          r_next = R_DATA;
          rd_sel = ARADDR[31:3];
          rd_en  = in_range(ARADDR[31:3], DEPTH);
        end else begin
          r_next = R_WAIT;
        end
      end
      R_WAIT: begin
        r_cnt_nx = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          r_next = R_DATA;
          rd_en  = r_in;
        end
      end
      R_DATA: if (RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Gating with ARESETn keeps the readies low during reset and lets them
  // rise as soon as reset is released.
  assign ARREADY = ARESETn && (r_state == R_IDLE);
  assign RVALID  = (r_state == R_DATA);
  assign RLAST   = (r_state == R_DATA);
  assign RRESP   = (r_state == R_DATA && !r_in) ? RESP_SLVERR : RESP_OKAY;
  assign RDATA   = (r_state == R_DATA &&  r_in) ? rd_data : 64'd0;

  // ---------------- write side ----------------
  wr_state_e   w_state, w_next;
  logic [3:0]  w_cnt, w_cnt_nx;
  logic        aw_got, aw_got_nx, w_got, w_got_nx;
  logic [28:0] w_word, w_word_nx;
  logic [63:0] wdata_q, wdata_nx;
  logic [7:0]  wstrb_q, wstrb_nx;
  logic        we, w_in;

  assign w_in = in_range(w_word, DEPTH);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      w_word  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      w_state <= w_next;
      w_cnt   <= w_cnt_nx;
      aw_got  <= aw_got_nx;
      w_got   <= w_got_nx;
      w_word  <= w_word_nx;
      wdata_q <= wdata_nx;
      wstrb_q <= wstrb_nx;
    end
  end

  // W_WAIT counts down to zero and commits on the zero cycle, so WR_LAT=0
  // still commits one cycle after the capture.
  always_comb begin
    w_next    = w_state;
    w_cnt_nx  = w_cnt;
    aw_got_nx = aw_got;
    w_got_nx  = w_got;
    w_word_nx = w_word;
    wdata_nx  = wdata_q;
    wstrb_nx  = wstrb_q;
    we        = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (AWVALID && !aw_got) begin
          aw_got_nx = 1'b1;
          w_word_nx = AWADDR[31:3];
        end
        if (WVALID && !w_got) begin
          w_got_nx = 1'b1;
          wdata_nx = WDATA;
          wstrb_nx = WSTRB;
        end
        if (aw_got_nx && w_got_nx) begin
          w_next   = W_WAIT;
          w_cnt_nx = WR_LAT_C;
        end
      end
      W_WAIT: begin
        if (w_cnt == 4'd0) begin
          we     = w_in && (wstrb_q != 8'd0);
          w_next = W_RESP;
        end else begin
          w_cnt_nx = w_cnt - 4'd1;
        end
      end
      W_RESP: if (BREADY) begin
        w_next    = W_IDLE;
        aw_got_nx = 1'b0;
        w_got_nx  = 1'b0;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign AWREADY = ARESETn && (w_state == W_IDLE) && !aw_got;
  assign WREADY  = ARESETn && (w_state == W_IDLE) && !w_got;
  assign BVALID  = (w_state == W_RESP);
  assign BRESP   = (w_state == W_RESP && !w_in) ? RESP_SLVERR : RESP_OKAY;

  sram_bank #(.DEPTH(DEPTH)) u_bank (
    .ACLK  (ACLK),
    .we    (we),
    .waddr (w_word[AW-1:0]),
    .wdata (wdata_q),
    .wstrb (wstrb_q),
    .re    (rd_en),
    .raddr (rd_sel[AW-1:0]),
    .rdata (rd_data)
  );

  // protection bits, byte offset and WLAST carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{ARPROT, AWPROT, ARADDR[2:0], AWADDR[2:0], WLAST, rd_sel};

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;
  import axi_pkg::*;

  localparam int DEPTH  = 64;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 2;

  logic        ACLK = 1'b0, ARESETn = 1'b0;
  logic        ARVALID = 0, RREADY = 0, AWVALID = 0, WVALID = 0, WLAST = 0, BREADY = 0;
  logic [31:0] ARADDR = '0, AWADDR = '0;
  logic [2:0]  ARPROT = '0, AWPROT = '0;
  logic [63:0] WDATA = '0;
  logic [7:0]  WSTRB = '0;
  logic        ARREADY, RVALID, RLAST, AWREADY, WREADY, BVALID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP, BRESP;

  axi_sram_slave #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0, n_bad = 0;

  typedef struct { logic [63:0] data; logic [1:0] resp; } rexp_t;
  rexp_t      rq[$];
  logic [1:0] bq[$];

  // reference memory: one 64-bit value per word index
  logic [63:0] model [logic [28:0]];

  function automatic bit in_rng(input logic [28:0] w);
    return 32'(w) < 32'(DEPTH);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", nm);
  endtask

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  // ---------------- monitors ----------------
  bit          r_stall = 0, b_stall = 0;
  logic [63:0] r_hold;
  logic [1:0]  r_hold_resp, b_hold;
  rexp_t       r_e;
  logic [1:0]  b_e;

  always @(negedge ACLK) begin
    if (!ARESETn) r_stall = 0;
    else begin
      if (r_stall) begin
        check("rvalid_held",  64'(RVALID), 64'd1);
        check("rdata_stable", RDATA, r_hold);
        check("rresp_stable", 64'(RRESP), 64'(r_hold_resp));
      end
      r_stall = 0;
      if (RVALID && RREADY) begin
        if (rq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL r_unexpected: got RDATA %h RRESP %b, none expected", RDATA, RRESP);
        end else begin
          r_e = rq.pop_front();
          check("rdata", RDATA, r_e.data);
          check("rresp", 64'(RRESP), 64'(r_e.resp));
          check("rlast", 64'(RLAST), 64'd1);
        end
      end else if (RVALID) begin
        r_stall = 1; r_hold = RDATA; r_hold_resp = RRESP;
      end
    end
  end

  always @(negedge ACLK) begin
    if (!ARESETn) b_stall = 0;
    else begin
      if (b_stall) begin
        check("bvalid_held",  64'(BVALID), 64'd1);
        check("bresp_stable", 64'(BRESP), 64'(b_hold));
      end
      b_stall = 0;
      if (BVALID && BREADY) begin
        if (bq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_unexpected: got BRESP %b, none expected", BRESP);
        end else begin
          b_e = bq.pop_front();
          check("bresp", 64'(BRESP), 64'(b_e));
        end
      end else if (BVALID) begin
        b_stall = 1; b_hold = BRESP;
      end
    end
  end

  // ---------------- channel drivers ----------------
  task automatic send_ar(input logic [31:0] a);
    bit hs = 0;
    ARADDR = a; ARPROT = 3'($urandom); ARVALID = 1;
    for (int k = 0; k < 30 && !hs; k++) begin @(negedge ACLK); hs = ARREADY; tick(); end
    ARVALID = 0;
    if (!hs) fail("ar_handshake");
  endtask

  task automatic send_aw(input logic [31:0] a);
    bit hs = 0;
    AWADDR = a; AWPROT = 3'($urandom); AWVALID = 1;
    for (int k = 0; k < 30 && !hs; k++) begin @(negedge ACLK); hs = AWREADY; tick(); end
    AWVALID = 0;
    if (!hs) fail("aw_handshake");
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s);
    bit hs = 0;
    WDATA = d; WSTRB = s; WLAST = 1'($urandom); WVALID = 1;
    for (int k = 0; k < 30 && !hs; k++) begin @(negedge ACLK); hs = WREADY; tick(); end
    WVALID = 0;
    if (!hs) fail("w_handshake");
  endtask

  // skew > 0: W leads AW by skew cycles; skew < 0: AW leads W
  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int skew, input int bdly);
    int n;
    bit aw_done = 0;
    if (in_rng(a[31:3])) begin
      for (int i = 0; i < 8; i++)
        if (s[i]) model[a[31:3]][8*i +: 8] = d[8*i +: 8];
      bq.push_back(RESP_OKAY);
    end else begin
      bq.push_back(RESP_SLVERR);
    end
    fork
      begin
        repeat (skew > 0 ? skew : 0) tick();
        send_aw(a);
        aw_done = 1;
      end
      begin
        repeat (skew < 0 ? -skew : 0) tick();
        send_w(d, s);
        if (!aw_done) begin
          @(negedge ACLK);
          check("wready_drop", 64'(WREADY), 64'd0);
        end
      end
    join
    repeat (bdly) tick();
    BREADY = 1;
    n = 0;
    while (!(BVALID && BREADY) && n < 40) begin @(negedge ACLK); n++; end
    if (!(BVALID && BREADY)) fail("b_timeout");
    tick();
    BREADY = 0;
  endtask

  task automatic do_read(input logic [31:0] a, input int rdly);
    int n;
    rexp_t e;
    e.resp = in_rng(a[31:3]) ? RESP_OKAY : RESP_SLVERR;
    e.data = in_rng(a[31:3]) ? model[a[31:3]] : 64'd0;
    rq.push_back(e);
    send_ar(a);
    if (rdly == 0) RREADY = 1;
    n = 0;
    @(negedge ACLK);
    while (!RVALID && n < 40) begin n++; @(negedge ACLK); end
    check("rd_latency", 64'(n), 64'(RD_LAT));
    check("arready_busy", 64'(ARREADY), 64'd0);
    if (rdly > 0) begin
      repeat (rdly) tick();
      RREADY = 1;
    end
    n = 0;
    while (!(RVALID && RREADY) && n < 40) begin @(negedge ACLK); n++; end
    if (!(RVALID && RREADY)) fail("r_timeout");
    tick();
    RREADY = 0;
    @(negedge ACLK);
    check("arready_back", 64'(ARREADY), 64'd1);
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_arready"}, 64'(ARREADY), 64'd0);
    check({tag, "_awready"}, 64'(AWREADY), 64'd0);
    check({tag, "_wready"},  64'(WREADY),  64'd0);
    check({tag, "_rvalid"},  64'(RVALID),  64'd0);
    check({tag, "_bvalid"},  64'(BVALID),  64'd0);
    check({tag, "_rdata"},   RDATA,        64'd0);
    check({tag, "_rlast"},   64'(RLAST),   64'd0);
    check({tag, "_rresp"},   64'(RRESP),   64'd0);
    check({tag, "_bresp"},   64'(BRESP),   64'd0);
  endtask

  task automatic release_reset();
    ARESETn = 1;
    @(negedge ACLK);
    check("post_rst_arready", 64'(ARREADY), 64'd1);
    check("post_rst_awready", 64'(AWREADY), 64'd1);
    check("post_rst_wready",  64'(WREADY),  64'd1);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [28:0] w;
    logic [31:0] a;
    logic [7:0]  s;

    tick(); tick();
    check_idle_outputs("rst");
    release_reset();

    // fill every word so later reads are fully defined
    for (int i = 0; i < DEPTH; i++)
      do_write(32'(i) << 3, {$urandom, $urandom}, 8'hFF, 0, 0);

    // full write then read back
    do_write(32'h10, 64'h1122334455667788, 8'hFF, 0, 0);
    do_read(32'h10, 0);
    // low-half strobe merge
    do_write(32'h10, 64'hFFFFFFFF_AAAAAAAA, 8'h0F, -1, 1);
    do_read(32'h10, 0);
    // W three cycles ahead of AW, slow BREADY
    do_write(32'h18, {$urandom, $urandom}, 8'hFF, 3, 4);
    do_read(32'h18, 0);
    // first out-of-range word, and its aliasing partner word 0 stays intact
    do_read(DEPTH * 8, 0);
    do_write(DEPTH * 8, {$urandom, $urandom}, 8'hFF, 0, 2);
    do_read(32'h0, 0);
    // five-cycle RREADY stall
    do_read(32'h18, 5);

    // reset during R_WAIT
    send_ar(32'h28);
    tick();
    ARESETn = 0; #1;
    check_idle_outputs("rst_rd");
    tick();
    release_reset();
    repeat (6) begin @(negedge ACLK); check("no_rvalid_after_rst", 64'(RVALID), 64'd0); end
    tick();

    // reset during W_WAIT: no commit, no response
    fork
      send_aw(32'h28);
      send_w(~model[29'd5], 8'hFF);
    join
    tick();
    ARESETn = 0; #1;
    check_idle_outputs("rst_wr");
    tick();
    release_reset();
    repeat (6) begin @(negedge ACLK); check("no_bvalid_after_rst", 64'(BVALID), 64'd0); end
    tick();
    do_read(32'h28, 0);

    // randomized traffic
    for (int it = 0; it < 200; it++) begin
      w = 29'($urandom_range(0, DEPTH + 7));
      if ($urandom_range(0, 15) == 0) w = 29'h1FFFFFFF - 29'($urandom_range(0, 3));
      a = {w, 3'($urandom)};
      if ($urandom_range(0, 1) == 0) begin
        s = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        do_write(a, {$urandom, $urandom}, s, $urandom_range(0, 6) - 3, $urandom_range(0, 5));
      end else begin
        do_read(a, $urandom_range(0, 4));
      end
    end

    repeat (5) tick();
    check("rq_drained", 64'(rq.size()), 64'd0);
    check("bq_drained", 64'(bq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning number of 64-bit words stored.
REQ-002 SHALL have parameter RD_LAT, default 2, meaning idle cycles between AR handshake and RVALID.
REQ-003 SHALL have parameter WR_LAT, default 2, meaning idle cycles between AW+W capture and the memory commit.
REQ-004 SHALL have port ACLK, input, 1, meaning clock; all logic is sampled on rising edge.
REQ-005 SHALL have port ARESETn, input, 1, meaning reset, asynchronous, active-low.
REQ-006 SHALL have read-address ports ARVALID (in, 1), ARREADY (out, 1), ARADDR (in, 32), ARPROT (in, 3, ignored).
REQ-007 SHALL have read-data ports RVALID (out, 1), RREADY (in, 1), RDATA (out, 64), RLAST (out, 1), RRESP (out, 2).
REQ-008 SHALL have write-address ports AWVALID (in, 1), AWREADY (out, 1), AWADDR (in, 32), AWPROT (in, 3, ignored).
REQ-009 SHALL have write-data ports WVALID (in, 1), WREADY (out, 1), WDATA (in, 64), WSTRB (in, 8), WLAST (in, 1).
REQ-010 SHALL have write-response ports BVALID (out, 1), BREADY (in, 1), BRESP (out, 2).

Function
REQ-011 SHALL index memory by word = ADDR[31:3]; ADDR[2:0] ignored; word >= DEPTH is out of range.
REQ-012 Read FSM SHALL have states R_IDLE, R_WAIT, R_DATA; ARREADY=1 only in R_IDLE.
REQ-013 On ARVALID&&ARREADY: latch word index, load counter with RD_LAT; go R_WAIT, or R_DATA directly if RD_LAT=0.
REQ-014 R_WAIT SHALL decrement the counter each cycle and enter R_DATA in the cycle after it reaches 1.
REQ-015 On entering R_DATA: sample memory into RDATA; RVALID=1, RLAST=1; RRESP=OKAY(00) in range, else SLVERR(10) with RDATA=0.
REQ-016 RDATA/RRESP/RLAST SHALL hold stable while RVALID&&!RREADY; on RVALID&&RREADY return to R_IDLE next cycle, RVALID=0.
REQ-017 Write FSM SHALL have states W_IDLE, W_WAIT, W_RESP; AW and W captured independently in W_IDLE.
REQ-018 In W_IDLE: AWREADY=1 until AW captured, WREADY=1 until W captured; both may capture in the same cycle.
REQ-019 When both captured: load counter with WR_LAT, go W_WAIT (WR_LAT=0: commit in the cycle following capture).
REQ-020 At commit: update each byte lane i where WSTRB[i]=1; no write when out of range or WSTRB=0.
REQ-021 After commit: enter W_RESP, BVALID=1, BRESP=OKAY or SLVERR (out of range); hold until BREADY, then W_IDLE.
REQ-022 WLAST=0 SHALL be treated as WLAST=1 (single-beat only); no burst support.
REQ-023 Read and write FSMs SHALL run concurrently; a read sample and a commit to the same word in one cycle SHALL return old data.
REQ-024 Memory SHALL have one write port and one read port; no other arbitration.

Reset
REQ-025 On ARESETn=0, asynchronously: both FSMs to IDLE, counters 0, captured flags cleared.
REQ-026 During reset: ARREADY=AWREADY=WREADY=0, RVALID=BVALID=0, RDATA=0, RLAST=0, RRESP=BRESP=00.
REQ-027 Reset mid-transaction SHALL abort it with no commit and no response; memory contents are not cleared.
REQ-028 ARREADY/AWREADY/WREADY SHALL rise in the first cycle after ARESETn deasserts.

Structure
REQ-029 Shared package axi_pkg SHALL hold RESP_OKAY=2'b00, RESP_SLVERR=2'b10, and the read/write FSM state enums.
REQ-030 Memory array with byte-strobe write and registered read SHALL be sub-module sram_bank (DEPTH x 64).
REQ-031 Parameters RD_LAT/WR_LAT SHALL support 0..15 with 4-bit counters.

Verification
REQ-032 Write AWADDR=0x10, WDATA=0x1122334455667788, WSTRB=0xFF, then read 0x10 -> RDATA=0x1122334455667788, RRESP=00, RLAST=1, RVALID after RD_LAT+1 cycles.
REQ-033 WSTRB=0x0F with WDATA=0xFFFFFFFF_AAAAAAAA over the prior word -> read returns 0x11223344_AAAAAAAA.
REQ-034 W presented 3 cycles before AW -> WREADY drops after W capture, single commit, exactly one BVALID pulse held until BREADY.
REQ-035 Read ARADDR=DEPTH*8 -> RRESP=10, RDATA=0; write there -> BRESP=10 and no memory change.
REQ-036 RREADY held low 5 cycles -> RVALID and RDATA stable all 5 cycles; AR only re-accepted after handshake.
REQ-037 ARESETn pulsed during R_WAIT and W_WAIT -> no RVALID/BVALID, target word keeps prior value.
